// File: rtl/fifo_burst_reader.sv
// Burst drain stage for the read side of an async FIFO: waits for a full burst (or a flushed
// remainder), then streams it out over valid/ready through a 2-entry skid buffer.
// Optional statistics counters are built when FIFO_BURST_READER_STAT_EN is defined.
module fifo_burst_reader #(
    parameter int DATA_WIDTH  = 16,
    parameter int DEPTH_WIDTH = 11,
    parameter int BURST_LEN   = 256
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   flush,
    output logic                   fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
    input  logic                   fifo_rd_empty,
    input  logic [DEPTH_WIDTH:0]   fifo_rd_level,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [DATA_WIDTH-1:0]  m_data,
    output logic                   m_last,
    output logic [DEPTH_WIDTH:0]   burst_len_o,
    output logic                   burst_done,
    output logic                   busy,
    output logic [31:0]            stat_words,
    output logic [15:0]            stat_bursts,
    output logic [31:0]            stat_stall
);

    localparam int LW = DEPTH_WIDTH + 1;
    localparam logic [LW-1:0] BURST_LEN_C = LW'(BURST_LEN);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic                   flush_pend_q, flush_pend_d;
    logic [LW-1:0]          len_q, len_d;
    logic [LW-1:0]          issued_q, issued_d;
    logic [LW-1:0]          accepted_q, accepted_d;
    logic                   inflight_q;
    logic [DATA_WIDTH-1:0]  buf_q [2];
    logic [DATA_WIDTH-1:0]  buf_d [2];
    logic                   wr_ptr_q, wr_ptr_d;
    logic                   rd_ptr_q, rd_ptr_d;
    logic [1:0]             buf_cnt_q, buf_cnt_d;

    logic                   push;
    logic                   pop;
    logic                   last_pop;
    logic [2:0]             occupancy;

    // Stream side: the skid buffer head is the output; the last tag is derived from the accept count.
    always_comb begin
        push       = inflight_q;
        m_valid    = (buf_cnt_q != 2'd0);
        m_data     = buf_q[rd_ptr_q];
        m_last     = m_valid && ((accepted_q + LW'(1)) == len_q);
        pop        = m_valid && m_ready;
        last_pop   = pop && m_last;
        burst_done = last_pop;
        busy       = (state_q == BURST);
        burst_len_o = len_q;
    end

    // The word leaving this cycle frees its slot, which sustains one word per cycle
    // while never holding more than two words between the buffer and the FIFO pipe.
    always_comb begin
        occupancy  = {1'b0, buf_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
        fifo_rd_en = (state_q == BURST) && !fifo_rd_empty
                     && (issued_q < len_q) && (occupancy < 3'd2);
    end

    // NOTE: every signal assigned in an always_comb gets a default first, so no path
    // through the case statement can leave it unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        flush_pend_d = flush_pend_q;
        len_d        = len_q;
        issued_d     = issued_q;
        accepted_d   = accepted_q;

        unique case (state_q)
            IDLE: begin
                if (en && (fifo_rd_level >= BURST_LEN_C)) begin
                    state_d      = BURST;
                    len_d        = BURST_LEN_C;
                    issued_d     = '0;
                    accepted_d   = '0;
                    flush_pend_d = 1'b0;
                end else if (en && flush_pend_q && (fifo_rd_level != '0)) begin
                    state_d      = BURST;
                    len_d        = (fifo_rd_level < BURST_LEN_C) ? fifo_rd_level : BURST_LEN_C;
                    issued_d     = '0;
                    accepted_d   = '0;
                    flush_pend_d = 1'b0;
                end else if (fifo_rd_empty && (fifo_rd_level == '0)) begin
                    flush_pend_d = 1'b0;
                end
            end
            BURST: begin
                issued_d   = issued_q + LW'(fifo_rd_en);
                accepted_d = accepted_q + LW'(pop);
                if (last_pop) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A new flush request is never lost, even when it coincides with a burst start.
        if (flush) begin
            flush_pend_d = 1'b1;
        end
    end

    always_comb begin
        buf_d     = buf_q;
        wr_ptr_d  = wr_ptr_q ^ push;
        rd_ptr_d  = rd_ptr_q ^ pop;
        buf_cnt_d = buf_cnt_q + {1'b0, push} - {1'b0, pop};
        if (push) begin
            buf_d[wr_ptr_q] = fifo_rd_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples
    // the pre-edge value of its inputs regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            flush_pend_q <= 1'b0;
            len_q        <= '0;
            issued_q     <= '0;
            accepted_q   <= '0;
            inflight_q   <= 1'b0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            buf_cnt_q    <= 2'd0;
            // NOTE: the two buffer words are reset because m_data is read straight from
            // them and must be zero out of reset; a deep memory would not be reset.
            for (int i = 0; i < 2; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            flush_pend_q <= flush_pend_d;
            len_q        <= len_d;
            issued_q     <= issued_d;
            accepted_q   <= accepted_d;
            inflight_q   <= fifo_rd_en;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            buf_cnt_q    <= buf_cnt_d;
            buf_q        <= buf_d;
        end
    end

`ifdef FIFO_BURST_READER_STAT_EN
    logic [31:0] stat_words_q, stat_words_d;
    logic [15:0] stat_bursts_q, stat_bursts_d;
    logic [31:0] stat_stall_q, stat_stall_d;

    // Saturating event counters; cleared only by reset.
    always_comb begin
        stat_words_d  = stat_words_q;
        stat_bursts_d = stat_bursts_q;
        stat_stall_d  = stat_stall_q;
        if (pop && (stat_words_q != '1)) begin
            stat_words_d = stat_words_q + 32'd1;
        end
        if (last_pop && (stat_bursts_q != '1)) begin
            stat_bursts_d = stat_bursts_q + 16'd1;
        end
        if (m_valid && !m_ready && (stat_stall_q != '1)) begin
            stat_stall_d = stat_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_words_q  <= '0;
            stat_bursts_q <= '0;
            stat_stall_q  <= '0;
        end else begin
            stat_words_q  <= stat_words_d;
            stat_bursts_q <= stat_bursts_d;
            stat_stall_q  <= stat_stall_d;
        end
    end

    assign stat_words  = stat_words_q;
    assign stat_bursts = stat_bursts_q;
    assign stat_stall  = stat_stall_q;
`else
    assign stat_words  = '0;
    assign stat_bursts = '0;
    assign stat_stall  = '0;
`endif

endmodule
